digit_serial_adder: RTL and testbench

Parametrised, multi-cycle add/subtract unit that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first. A shared combinational DIGIT-bit slice does the arithmetic, so area stays small at wide WIDTH. The block extends the team's 4-bit ripple adder with configurable width and digit size, a subtract mode, a signed-overflow flag and a start/done handshake. It sits beside the ALU datapath as the reusable wide adder.

---
 rtl/digit_serial_adder_pkg.sv | 14 +
 rtl/digit_serial_adder_slice.sv | 20 ++
 rtl/digit_serial_adder.sv | 115 +++++++++++
 tb/tb_digit_serial_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared FSM encoding and default sizes for the digit-serial adder
// Exports: state_t (IDLE/RUN/DONE), DEF_WIDTH, DEF_DIGIT
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/digit_serial_adder_slice.sv
// digit_serial_adder_slice: combinational DIGIT-bit adder slice shared by every digit cycle
// Ports: a, b (DIGIT-bit digits), ci (carry in) -> sum, co (carry out), c_msb (carry into the top bit)
module digit_serial_adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    always_comb begin
        {co, sum} = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(ci);
        // the top sum bit is a^b^carry_in, so the carry that entered it falls out by xor
        c_msb = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract done DIGIT bits per clock, LSB digit first
// Ports: clk, rst_n (sync, active low); start/sub/c_in/x/y request, latched on accept while ready;
//        ready (IDLE or DONE), done (one-cycle result pulse); registered s, c_out (not-borrow on sub), ovf
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = $clog2(N) + 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $fatal(1, "digit_serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
    logic              carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [DIGIT-1:0]  sum;
    logic              co, c_msb, accept, last;
    logic [WIDTH-1:0]  r_shift;

    digit_serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .sum   (sum),
        .co    (co),
        .c_msb (c_msb)
    );

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign done  = state_q == DONE;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        accept  = start && ready;
        last    = k_q == KW'(N - 1);
        // shifting through the concatenation keeps the DIGIT == WIDTH case free of empty slices
        r_shift = WIDTH'({sum, r_q} >> DIGIT);
        if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            r_d     = r_shift;
            carry_d = co;
            k_d     = k_q + KW'(1);
            if (last) begin
                state_d = DONE;
                s_d     = r_shift;
                c_out_d = co;
                ovf_d   = co ^ c_msb;
            end
        end else begin
            state_d = accept ? RUN : IDLE;
            if (accept) begin
                a_d     = x;
                b_d     = sub ? ~y : y;
                carry_d = c_in ^ sub;
                k_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: vector table, handshake/reset sequences and random ops against an arithmetic model
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, sub_a = 1'b0, cin_a = 1'b0;
    logic [15:0] x_a = '0, y_a = '0;
    logic        ready_a, done_a, cout_a, ovf_a;
    logic [15:0] s_a;
    logic        start_b = 1'b0, sub_b = 1'b0, cin_b = 1'b0;
    logic [3:0]  x_b = '0, y_b = '0;
    logic        ready_b, done_b, cout_b, ovf_b;
    logic [3:0]  s_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sub(sub_a), .c_in(cin_a), .x(x_a), .y(y_a),
        .ready(ready_a), .done(done_a), .s(s_a), .c_out(cout_a), .ovf(ovf_a)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_narrow (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sub(sub_b), .c_in(cin_b), .x(x_b), .y(y_b),
        .ready(ready_b), .done(done_b), .s(s_b), .c_out(cout_b), .ovf(ovf_b)
    );

    typedef struct {
        bit          sel;
        logic        sub;
        logic        cin;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow is the signed result leaving the w-bit range
    function automatic void model(input int w, input logic [15:0] x, input logic [15:0] y,
                                  input logic sub, input logic cin,
                                  output logic [15:0] s, output logic c, output logic o);
        longint m, full, sx, sy, t;
        m    = (longint'(1) << w) - 1;
        full = sub ? (longint'(x) & m) + (longint'(~y) & m) + longint'(!cin)
                   : (longint'(x) & m) + (longint'(y) & m) + longint'(cin);
        s    = 16'(full & m);
        c    = full[w];
        sx   = longint'(x) & m;
        sy   = longint'(y) & m;
        if (sx >= (longint'(1) << (w - 1))) sx -= longint'(1) << w;
        if (sy >= (longint'(1) << (w - 1))) sy -= longint'(1) << w;
        t    = sub ? sx - sy - longint'(cin) : sx + sy + longint'(cin);
        o    = (t >= (longint'(1) << (w - 1))) || (t < -(longint'(1) << (w - 1)));
    endfunction

    task automatic launch(input bit sel, input logic [15:0] x, input logic [15:0] y,
                          input logic sub, input logic cin);
        @(negedge clk);
        chk("ready_before_start", {31'b0, sel ? ready_b : ready_a}, 32'd1);
        if (sel) begin
            start_b = 1'b1; x_b = x[3:0]; y_b = y[3:0]; sub_b = sub; cin_b = cin;
        end else begin
            start_a = 1'b1; x_a = x; y_a = y; sub_a = sub; cin_a = cin;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // lat counts edges with the accept edge as 1; the done edge of an N-digit op is edge N+1
    task automatic wait_done(input bit sel, output int lat);
        lat = 1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(sel ? done_b : done_a) && lat < 64);
    endtask

    task automatic do_op(input bit sel, input logic [15:0] x, input logic [15:0] y,
                         input logic sub, input logic cin,
                         output logic [15:0] s, output logic c, output logic o, output int lat);
        launch(sel, x, y, sub, cin);
        wait_done(sel, lat);
        s = sel ? {12'b0, s_b} : s_a;
        c = sel ? cout_b : cout_a;
        o = sel ? ovf_b : ovf_a;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] rs, es, xr, yr, s_prev;
        logic        rc, ro, ec, eo, sr, cr;
        int          lat, lat2, pulses;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h000F, 16'h000F, 16'h000F, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h000A, 16'h000F, 16'h000A, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h0234, 16'h0FFF, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, ready_a}, 32'd1);
        chk("reset_done", {31'b0, done_a}, 32'd0);
        chk("reset_s", {16'b0, s_a}, 32'd0);
        chk("reset_cout", {31'b0, cout_a}, 32'd0);
        chk("reset_ovf", {31'b0, ovf_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].sub, vecs[i].cin, rs, rc, ro, lat);
            chk($sformatf("vec%0d_s", i), {16'b0, rs}, {16'b0, vecs[i].s});
            chk($sformatf("vec%0d_cout", i), {31'b0, rc}, {31'b0, vecs[i].c});
            chk($sformatf("vec%0d_ovf", i), {31'b0, ro}, {31'b0, vecs[i].o});
            chk($sformatf("vec%0d_latency", i), lat, 32'd5);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_width", i), {31'b0, vecs[i].sel ? done_b : done_a}, 32'd0);
        end

        // start and operand changes during RUN are ignored; outputs hold the previous result
        s_prev = s_a;
        launch(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        start_a = 1'b1; x_a = 16'hFFFF; y_a = 16'hFFFF; sub_a = 1'b1; cin_a = 1'b1;
        chk("run_ready_low", {31'b0, ready_a}, 32'd0);
        chk("run_s_hold", {16'b0, s_a}, {16'b0, s_prev});
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, lat);
        chk("ignore_s", {16'b0, s_a}, 32'h2345);
        chk("ignore_cout", {31'b0, cout_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("ignore_no_second_done", {31'b0, done_a}, 32'd0);

        // back-to-back: start held in the DONE cycle is accepted
        launch(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        start_a = 1'b1; x_a = 16'h4000; y_a = 16'h4000; sub_a = 1'b0; cin_a = 1'b0;
        chk("b2b_first_s", {16'b0, s_a}, 32'h0100);
        chk("b2b_ready_in_done", {31'b0, ready_a}, 32'd1);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("b2b_running", {31'b0, ready_a}, 32'd0);
        wait_done(1'b0, lat2);
        chk("b2b_spacing", lat2, 32'd5);
        chk("b2b_second_s", {16'b0, s_a}, 32'h8000);
        chk("b2b_second_ovf", {31'b0, ovf_a}, 32'd1);

        // reset at digit k=2 discards the operation
        launch(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_s", {16'b0, s_a}, 32'd0);
        chk("rst_mid_cout", {31'b0, cout_a}, 32'd0);
        chk("rst_mid_ovf", {31'b0, ovf_a}, 32'd0);
        chk("rst_mid_ready", {31'b0, ready_a}, 32'd1);
        chk("rst_mid_done", {31'b0, done_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_a) pulses++;
        end
        chk("rst_mid_no_done", pulses, 32'd0);
        do_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b1, rs, rc, ro, lat);
        chk("rst_after_s", {16'b0, rs}, 32'h1011);
        chk("rst_after_latency", lat, 32'd5);

        for (int i = 0; i < 200; i++) begin
            bit sel;
            sel = (i % 4) == 3;
            xr  = 16'($urandom);
            yr  = 16'($urandom);
            sr  = 1'($urandom);
            cr  = 1'($urandom);
            model(sel ? 4 : 16, xr, yr, sr, cr, es, ec, eo);
            do_op(sel, xr, yr, sr, cr, rs, rc, ro, lat);
            chk($sformatf("rand%0d_s x=%h y=%h sub=%b cin=%b", i, xr, yr, sr, cr), {16'b0, rs}, {16'b0, es});
            chk($sformatf("rand%0d_cout", i), {31'b0, rc}, {31'b0, ec});
            chk($sformatf("rand%0d_ovf", i), {31'b0, ro}, {31'b0, eo});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
